// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared seven-segment patterns and display slot definitions.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Cathode patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_TENTHS = 2'd0;
    localparam slot_t SLOT_SU     = 2'd1;
    localparam slot_t SLOT_ST     = 2'd2;
    localparam slot_t SLOT_MIN    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_7seg
// Brief    : Combinational BCD to active-low seven-segment decoder; 10-15 blank.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan
// Brief    : 4-digit multiplexed display scanner (M.SS.T) with frame snapshot,
//            anode guard time and optional blink (macro DISP_BLINK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_min,
    input  logic [3:0] digit_st,
    input  logic [3:0] digit_su,
    input  logic [3:0] digit_tenths,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_guard    = CNT_W'(GUARD_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    slot_t            r_slot;
    logic [3:0][3:0]  r_snap;
    logic [3:0][3:0]  w_frame;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg;
    logic [3:0]       w_an;
    logic             w_wrap;
    logic             w_load;
    logic             w_blank;

    assign w_wrap = (r_cnt == c_cnt_last);
    assign w_load = (r_slot == SLOT_TENTHS) && (r_cnt == '0);

    // The snapshot loading this cycle is decoded directly, so slot 0 never
    // shows a stale digit for its first cycle.
    assign w_frame = w_load ? {digit_min, digit_st, digit_su, digit_tenths} : r_snap;
    assign w_digit = w_frame[r_slot];

    bcd_to_7seg u_dec (
        .bcd (w_digit),
        .seg (w_seg)
    );

`ifdef DISP_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] c_fc_last = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] r_fcnt;
    logic            r_phase_off;
    logic            w_frame_end;

    assign w_frame_end = w_wrap && (r_slot == SLOT_MIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt      <= '0;
            r_phase_off <= 1'b0;
        end else if (!blink) begin
            r_fcnt      <= '0;
            r_phase_off <= 1'b0;
        end else if (w_frame_end) begin
            if (r_fcnt == c_fc_last) begin
                r_fcnt      <= '0;
                r_phase_off <= ~r_phase_off;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_blank = blink && r_phase_off;
`else
    logic w_unused_blink;
    assign w_unused_blink = blink;
    assign w_blank        = 1'b0;
`endif

    always_comb begin
        w_an = 4'b1111;
        if (!(r_cnt < c_guard) && !w_blank) begin
            w_an = ~(4'b0001 << r_slot);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= SLOT_TENTHS;
            r_snap <= '0;
            an     <= 4'b1111;
            seg    <= SEG_OFF;
            dp     <= 1'b1;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_slot <= w_wrap ? r_slot + 2'd1 : r_slot;
            r_snap <= w_frame;
            an     <= w_an;
            seg    <= w_seg;
            dp     <= ~r_slot[0];
        end
    end

endmodule
`default_nettype wire

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal range 2 to 2^20.
REQ-002 Parameter GUARD_CYCLES, default 1000, all-anodes-off cycles at the start of each slot; legal range 0 to REFRESH_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 128, frames per blink half-period; legal range 1 to 1023.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 digit_min  in  4  BCD minutes digit.
REQ-007 digit_st  in  4  BCD seconds-tens digit.
REQ-008 digit_su  in  4  BCD seconds-units digit.
REQ-009 digit_tenths  in  4  BCD tenths digit.
REQ-010 blink  in  1  request to flash the whole display; used only under DISP_BLINK_EN.
REQ-011 an  out  4  anode enables, active-low; an[0] is the rightmost digit (tenths), an[3] is minutes.
REQ-012 seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-013 dp  out  1  decimal point, active-low.

Function
REQ-014 A refresh counter SHALL count 0 to REFRESH_DIV-1 and wrap to 0.
REQ-015 Slot index SHALL advance 0,1,2,3,0 on each refresh-counter wrap: 0 = tenths, 1 = su, 2 = st, 3 = min.
REQ-016 All four digit inputs SHALL be latched into a frame snapshot on every cycle where slot = 0 and the refresh counter = 0; this includes the first such cycle after reset.
REQ-017 Slot content SHALL come only from the snapshot, so digit changes mid-frame never tear the display.
REQ-018 an SHALL be 4'b1111 while the refresh counter < GUARD_CYCLES, and one-hot-low at the current slot otherwise.
REQ-019 seg SHALL show the decoded snapshot digit for the current slot for the whole slot, guard period included.
REQ-020 Decode 0 to 9 SHALL use standard patterns (e.g. 0 gives 7'b1000000, 8 gives 7'b0000000); codes 10 to 15 SHALL give 7'b1111111.
REQ-021 dp SHALL be 0 in slots 1 and 3 (display format M.SS.T) and 1 in slots 0 and 2.
REQ-022 an, seg and dp SHALL be registered, reflecting counter and slot state with exactly 1 cycle latency.
REQ-023 GUARD_CYCLES = 0 SHALL give no all-off cycles; an is then never 4'b1111 outside reset and blink.

Reset
REQ-024 On rst: refresh counter 0, slot 0, snapshot 0, blink phase "on", frame counter 0.
REQ-025 While rst is asserted, outputs SHALL be an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-026 Reset asserted mid-slot SHALL force the reset values immediately, with no completion of the current slot.
REQ-027 On the first rising edge after rst deasserts, the snapshot SHALL load (per REQ-016) and slot 0 SHALL begin its guard period.

Configuration
REQ-028 With macro DISP_BLINK_EN defined:
- a frame counter SHALL count completed frames (slot 3 to 0 wraps);
- blink phase SHALL toggle every BLINK_FRAMES frames;
- while blink = 1 and phase = "off", an SHALL be 4'b1111;
- when blink = 0, phase SHALL reset to "on" and the frame counter to 0.
REQ-029 Without DISP_BLINK_EN, the blink port SHALL remain present but be ignored, and no frame counter or blink logic SHALL be synthesised.

Structure
REQ-030 Shared package stopwatch_pkg SHALL hold:
- SEG_0 to SEG_9 and SEG_OFF pattern constants;
- a 2-bit slot-index typedef;
- slot constants SLOT_TENTHS, SLOT_SU, SLOT_ST, SLOT_MIN.
REQ-031 One combinational sub-module bcd_to_7seg (4-bit in, 7-bit active-low out) SHALL perform decode.
REQ-032 Counter and snapshot logic SHALL live in sevenseg_scan.

Verification (REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_FRAMES=2)
REQ-033 Inputs min=1, st=2, su=3, tenths=4 held after reset. Per 8-cycle slot, expect:
- an = 1111 for 2 cycles, then 1110, 1101, 1011, 0111 in slots 0 to 3;
- seg = patterns for 4, 3, 2, 1;
- dp low only in slots 1 and 3.
REQ-034 digit_su changes 3 to 7 during slot 2. Slot 1 still shows 3 until the next frame snapshot, then shows 7.
REQ-035 digit_st = 4'hC. Slot 2 seg = 7'b1111111 and an still enables in its non-guard cycles.
REQ-036 rst pulsed during slot 2, cycle 5. Outputs go to reset values asynchronously, then slot 0 guard begins on the first edge after release.
REQ-037 Under DISP_BLINK_EN, blink = 1 for 8 frames. Expect an = 1111 for frames 3 to 4 and 7 to 8, normal otherwise; dropping blink restores display on the next slot.
